// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit queue.
//               Holds the pacing-FSM state enum, default baud divisors for a
//               50 MHz clock at 9600 baud, and the frame hold-off helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } uart_txq_state_t;

    // Divisor and half-bit capture point for 9600 baud from 50 MHz.
    localparam logic [12:0] BAUD_DIV_9600_50M = 13'd5208;
    localparam logic [12:0] BAUD_CAP_9600_50M = 13'd2604;

    // Clocks needed for one full frame (start + 8 data + stop = 10 bits) plus
    // one bit of margin, at (div+1) clocks per bit.
    function automatic int unsigned frame_hold(input int unsigned div);
        return 11 * (div + 1);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with registered read data.
//   clk     in  1         clock, rising edge
//   rst     in  1         synchronous active-high reset
//   i_push  in  1         write i_data (ignored when full)
//   i_pop   in  1         load head into o_data and advance (ignored when empty)
//   i_data  in  WIDTH     write data
//   o_data  out WIDTH     registered head captured by the last pop
//   o_level out AW+1      occupancy 0..DEPTH
//   o_full  out 1         occupancy == DEPTH
//   o_empty out 1         occupancy == 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_PTR_W = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0]   r_rd_data;
    logic               w_do_push;
    logic               w_do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign o_full    = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_rd_data;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the pointers define valid content.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rd_ptr[c_AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte queue and pacing stage in front of a UART transmitter
//               that has no busy flag. Bytes arrive on a valid/ready stream,
//               are buffered, and are released one per frame time as a data
//               bus plus a one-cycle enable strobe.
//   clk_i          in  1        system clock
//   rst_i          in  1        synchronous active-high reset
//   s_data_i       in  8        byte to queue
//   s_valid_i      in  1        s_data_i valid
//   s_ready_o      out 1        queue not full
//   uart_tx_data_o out 8        byte to transmitter, held until next strobe
//   uart_tx_en_o   out 1        one-cycle send strobe
//   busy_o         out 1        pacing in progress or bytes pending
//   level_o        out AW+1     FIFO occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [12:0] BAUD_DIV    = BAUD_DIV_9600_50M,
    parameter int          HOLD_CYCLES = int'(frame_hold(32'(BAUD_DIV)))
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              s_data_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [7:0]              uart_tx_data_o,
    output logic                    uart_tx_en_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);

    uart_txq_state_t    r_state;
    uart_txq_state_t    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_en;
    logic               w_en_nxt;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    // Ready depends only on registered occupancy, so a pop on the same edge
    // never opens a slot for a push that edge.
    assign s_ready_o    = !w_full;
    assign uart_tx_en_o = r_en;
    assign busy_o       = (r_state != ST_IDLE) || !w_empty;

    // The FIFO's registered read data doubles as the transmitter data bus:
    // it changes only on a pop, which is exactly the strobe edge.
    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (s_valid_i),
        .i_pop   (w_pop),
        .i_data  (s_data_i),
        .o_data  (uart_tx_data_o),
        .o_level (level_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Reset lands in HOLD so a frame already leaving the transmitter, which
    // is not reset, can finish before the next strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_HOLD;
            r_cnt   <= c_HOLD_LOAD;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = c_HOLD_LOAD;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = c_HOLD_LOAD;
            end
        endcase
    end

endmodule : uart_tx_queue
`default_nettype wire
